// File: rtl/bcd_counter_scan.sv
// bcd_counter_scan: N-digit BCD up/down counter driving a multiplexed common-anode 7-segment display.
// Latency: count updates on the prescaled tick edge; anode/cathode registered 1 cycle after index/bcd.
// Backpressure: none; free-running display scan, counting gated only by switch/clear.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
// Reset is synchronous active-low; all outputs are registered.
module bcd_counter_scan #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 5_000_000,
  parameter int SCAN_DIV = 50_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                switch,
  input  logic                up_dn,
  input  logic                clear,
  output logic [4*DIGITS-1:0] bcd,
  output logic                wrap,
  output logic [DIGITS-1:0]   anode,
  output logic [7:0]          cathode
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  logic [TW-1:0]       r_tick_cnt;
  logic [SW-1:0]       r_scan_cnt;
  logic [IW-1:0]       r_scan_idx;
  logic [4*DIGITS-1:0] r_bcd;
  logic                r_wrap;
  logic [DIGITS-1:0]   r_anode;
  logic [7:0]          r_cathode;

  logic                w_tick;
  logic                w_scan_step;
  logic [4*DIGITS-1:0] w_bcd_nxt;
  logic                w_carry;
  logic [3:0]          w_cnt_dig;
  logic [3:0]          w_dig;
  logic                w_cur_blank;
`ifdef LEADING_ZERO_BLANK_EN
  logic                w_zero_above;
`endif

  // Active-low gfedcba segment pattern for one decimal digit; non-decimal codes blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign w_tick      = (r_tick_cnt == TICK_LAST);
  assign w_scan_step = (r_scan_cnt == SCAN_LAST);

  // Ripple increment/decrement across digits; carry out of the top digit is a full-range wrap.
  always_comb begin
    w_bcd_nxt = r_bcd;
    w_carry   = 1'b1;
    w_cnt_dig = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      w_cnt_dig = r_bcd[4*i +: 4];
      if (w_carry) begin
        if (up_dn) begin
          if (w_cnt_dig >= 4'd9) begin
            w_bcd_nxt[4*i +: 4] = 4'd0;
          end else begin
            w_bcd_nxt[4*i +: 4] = w_cnt_dig + 4'd1;
            w_carry             = 1'b0;
          end
        end else begin
          if (w_cnt_dig == 4'd0) begin
            w_bcd_nxt[4*i +: 4] = 4'd9;
          end else if (w_cnt_dig > 4'd9) begin
            // Illegal code can't occur from reset; fold it back into range.
            w_bcd_nxt[4*i +: 4] = 4'd9;
            w_carry             = 1'b0;
          end else begin
            w_bcd_nxt[4*i +: 4] = w_cnt_dig - 4'd1;
            w_carry             = 1'b0;
          end
        end
      end
    end
  end

  // Select the scanned digit and decide whether it is a blanked leading zero.
  always_comb begin
    w_dig       = 4'd0;
    w_cur_blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    w_zero_above = 1'b1;
`endif
    for (int i = DIGITS - 1; i >= 0; i--) begin
`ifdef LEADING_ZERO_BLANK_EN
      w_zero_above = w_zero_above & (r_bcd[4*i +: 4] == 4'd0);
`endif
      if (IW'(i) == r_scan_idx) begin
        w_dig = r_bcd[4*i +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        w_cur_blank = (i != 0) && w_zero_above;
`endif
      end
    end
  end

  // Count-tick prescaler; clear realigns it so the next tick is a full period away.
  always_ff @(posedge clk) begin
    if (!rst_n || clear || w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TW'(1);
    end
  end

  // Counter state and one-cycle wrap pulse; clear has priority over counting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bcd  <= '0;
      r_wrap <= 1'b0;
    end else if (clear) begin
      r_bcd  <= '0;
      r_wrap <= 1'b0;
    end else if (w_tick && switch) begin
      r_bcd  <= w_bcd_nxt;
      r_wrap <= w_carry;
    end else begin
      r_wrap <= 1'b0;
    end
  end

  // Scan prescaler and digit index, free-running regardless of count controls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_scan_cnt <= '0;
      r_scan_idx <= '0;
    end else if (w_scan_step) begin
      r_scan_cnt <= '0;
      r_scan_idx <= (r_scan_idx == IDX_LAST) ? '0 : r_scan_idx + IW'(1);
    end else begin
      r_scan_cnt <= r_scan_cnt + SW'(1);
    end
  end

  // Registered display drive: one anode low, segments for that digit, dp off.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_anode   <= '1;
      r_cathode <= 8'hFF;
    end else begin
      r_anode   <= ~(DIGITS'(1) << r_scan_idx);
      r_cathode <= w_cur_blank ? 8'hFF : {1'b1, seg7(w_dig)};
    end
  end

  assign bcd     = r_bcd;
  assign wrap    = r_wrap;
  assign anode   = r_anode;
  assign cathode = r_cathode;

endmodule

// File: tb/tb_bcd_counter_scan.sv
// tb_bcd_counter_scan: directed stimulus with a per-cycle integer model of count, ticks and scan.
// Latency: outputs compared every falling edge once the model has seen a reset edge.
// Backpressure: n/a.
module tb_bcd_counter_scan;

  localparam int DIGITS   = 4;
  localparam int TICK_DIV = 4;
  localparam int SCAN_DIV = 2;
  localparam int MOD      = 10000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        switch;
  logic        up_dn;
  logic        clear;
  logic [15:0] bcd;
  logic        wrap;
  logic [3:0]  anode;
  logic [7:0]  cathode;

  int tests = 0;
  int fails = 0;

  // model state
  int         m_count, m_tp, m_sp, m_idx;
  bit         m_wrap;
  logic [3:0] m_anode;
  logic [7:0] m_cath;
  bit         m_init = 1'b0;

  bcd_counter_scan #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .switch(switch), .up_dn(up_dn), .clear(clear),
    .bcd(bcd), .wrap(wrap), .anode(anode), .cathode(cathode)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int p10(input int n);
    int r = 1;
    for (int k = 0; k < n; k++) r = r * 10;
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r = '0;
    int x = v;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  // Behavioural model: integer count modulo 10^DIGITS, display from previous-cycle state.
  initial forever begin
    int  digit;
    bit  tick, blank;
    @(posedge clk);
    if (!rst_n) begin
      m_count = 0; m_wrap = 0; m_tp = 0; m_sp = 0; m_idx = 0;
      m_anode = 4'hF; m_cath = 8'hFF; m_init = 1'b1;
    end else begin
      m_anode = ~(4'b0001 << m_idx);
      digit   = (m_count / p10(m_idx)) % 10;
      blank   = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      blank   = (m_idx > 0) && ((m_count / p10(m_idx)) == 0);
`endif
      m_cath  = blank ? 8'hFF : {1'b1, seg_of(digit)};
      tick    = (m_tp == TICK_DIV - 1);
      m_wrap  = 1'b0;
      if (clear) begin
        m_count = 0;
        m_tp    = 0;
      end else begin
        m_tp = tick ? 0 : m_tp + 1;
        if (tick && switch) begin
          if (up_dn) begin
            if (m_count == MOD - 1) m_wrap = 1'b1;
            m_count = (m_count + 1) % MOD;
          end else begin
            if (m_count == 0) m_wrap = 1'b1;
            m_count = (m_count + MOD - 1) % MOD;
          end
        end
      end
      if (m_sp == SCAN_DIV - 1) begin
        m_sp  = 0;
        m_idx = (m_idx + 1) % DIGITS;
      end else begin
        m_sp = m_sp + 1;
      end
    end
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (m_init) begin
      check("cyc_bcd", bcd, to_bcd(m_count));
      check("cyc_wrap", wrap, m_wrap);
      check("cyc_anode", anode, m_anode);
      check("cyc_cathode", cathode, m_cath);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sync_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  // Check all four digit positions over a few scan steps against hand tables.
  task automatic disp_check(input string name, input logic [7:0] ce, input logic [7:0] cd,
                            input logic [7:0] cb, input logic [7:0] c7);
    for (int k = 0; k < 8; k++) begin
      step(1);
      case (anode)
        4'hE: check(name, cathode, ce);
        4'hD: check(name, cathode, cd);
        4'hB: check(name, cathode, cb);
        default: check(name, cathode, c7);
      endcase
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int found, wrap_hi, bad, changes;
    logic [3:0] prev;
    rst_n = 1'b0; switch = 1'b0; up_dn = 1'b1; clear = 1'b0;

    // 1: reset state, then first scanned digit
    step(2);
    check("t1_bcd", bcd, 16'h0000);
    check("t1_anode", anode, 4'hF);
    check("t1_cathode", cathode, 8'hFF);
    check("t1_wrap", wrap, 1'b0);
    rst_n = 1'b1;
    found = 0;
    for (int k = 0; k < 3 && found == 0; k++) begin
      step(1);
      if (anode == 4'hE) found = 1;
    end
    check("t1_anode_rel", anode, 4'hE);
    check("t1_cathode_rel", cathode, 8'hC0);

    // 2: count up 12 ticks, no wrap
    sync_clear();
    switch = 1'b1; up_dn = 1'b1;
    wrap_hi = 0;
    for (int k = 0; k < 12 * TICK_DIV; k++) begin
      step(1);
      if (wrap) wrap_hi++;
    end
    check("t2_bcd", bcd, 16'h0012);
    check("t2_no_wrap", wrap_hi, 0);

    // 4: down from zero wraps to 9999, then 9998
    sync_clear();
    up_dn = 1'b0;
    step(TICK_DIV);
    check("t4_bcd_9999", bcd, 16'h9999);
    check("t4_wrap_hi", wrap, 1'b1);
    step(1);
    check("t4_wrap_lo", wrap, 1'b0);
    step(TICK_DIV - 1);
    check("t4_bcd_9998", bcd, 16'h9998);

    // 3: up through 9999 to 0000 with a one-cycle wrap
    up_dn = 1'b1;
    step(TICK_DIV);
    check("t3_bcd_9999", bcd, 16'h9999);
    check("t3_nowrap", wrap, 1'b0);
    step(TICK_DIV);
    check("t3_bcd_0000", bcd, 16'h0000);
    check("t3_wrap_hi", wrap, 1'b1);
    step(1);
    check("t3_wrap_lo", wrap, 1'b0);

    // 5: reach 0037, hold with switch=0, then clear on a tick edge
    sync_clear();
    switch = 1'b1; up_dn = 1'b1;
    step(37 * TICK_DIV);
    check("t5_bcd_0037", bcd, 16'h0037);
    switch = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    disp_check("t5_disp", 8'hF8, 8'hB0, 8'hFF, 8'hFF);
`else
    disp_check("t5_disp", 8'hF8, 8'hB0, 8'hC0, 8'hC0);
`endif
    bad = 0; changes = 0; prev = anode;
    for (int k = 0; k < 20 * TICK_DIV; k++) begin
      step(1);
      if (anode != prev) begin
        changes++;
        if (anode != {prev[2:0], prev[3]}) bad++;
      end
      prev = anode;
    end
    check("t5_hold_bcd", bcd, 16'h0037);
    check("t5_scan_order", bad, 0);
    check("t5_scan_moving", changes >= 30, 1'b1);
    step(TICK_DIV - 1);
    clear = 1'b1; switch = 1'b1;
    step(1);
    clear = 1'b0;
    check("t5_clear_bcd", bcd, 16'h0000);
    check("t5_clear_nowrap", wrap, 1'b0);

    // 6: value 5, leading zeros blanked or shown depending on build
    step(5 * TICK_DIV);
    check("t6_bcd_0005", bcd, 16'h0005);
    switch = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    disp_check("t6_disp", 8'h92, 8'hFF, 8'hFF, 8'hFF);
`else
    disp_check("t6_disp", 8'h92, 8'hC0, 8'hC0, 8'hC0);
`endif

    // mid-count reset returns everything to reset values
    switch = 1'b1;
    step(6);
    rst_n = 1'b0;
    step(1);
    check("rst_bcd", bcd, 16'h0000);
    check("rst_anode", anode, 4'hF);
    check("rst_cathode", cathode, 8'hFF);
    rst_n = 1'b1;
    step(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
